// File: rtl/bids22_host_if.sv
// ============================================================================
// Module   : bids22_host_if
// Brief    : Host-side request/result and auction command bundle for bids22_host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bids22_host_if #(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 3
);
    localparam int OPW  = 4;
    localparam int ERRW = 2;

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [DATAWIDTH-1:0]  cfg_key;
    logic [DATAWIDTH-1:0]  cfg_x;
    logic [DATAWIDTH-1:0]  cfg_y;
    logic [DATAWIDTH-1:0]  cfg_z;
    logic [DATAWIDTH-1:0]  cfg_timer;
    logic [DATAWIDTH-1:0]  cfg_charge;
    logic [NUMBIDDERS-1:0] cfg_mask;
    logic [15:0]           cfg_roundlen;

    logic [OPW-1:0]        C_op;
    logic [DATAWIDTH-1:0]  C_data;
    logic                  C_start;

    logic                  ready;
    logic                  roundOver;
    logic [DATAWIDTH-1:0]  maxBid;
    logic [ERRW-1:0]       err;
    logic [NUMBIDDERS-1:0] win;

    logic                  res_valid;
    logic                  res_ready;
    logic [DATAWIDTH-1:0]  res_maxbid;
    logic [NUMBIDDERS-1:0] res_win;
    logic [1:0]            res_err;

    modport master (
        input  cfg_valid, cfg_key, cfg_x, cfg_y, cfg_z, cfg_timer, cfg_charge,
               cfg_mask, cfg_roundlen,
        output cfg_ready,
        output C_op, C_data, C_start,
        input  ready, roundOver, maxBid, err, win,
        output res_valid, res_maxbid, res_win, res_err,
        input  res_ready
    );

    modport slave (
        output cfg_valid, cfg_key, cfg_x, cfg_y, cfg_z, cfg_timer, cfg_charge,
               cfg_mask, cfg_roundlen,
        input  cfg_ready,
        input  C_op, C_data, C_start,
        output ready, roundOver, maxBid, err, win,
        input  res_valid, res_maxbid, res_win, res_err,
        output res_ready
    );
endinterface

`default_nettype wire

// File: rtl/bids22_host.sv
// ============================================================================
// Module   : bids22_host
// Brief    : Controller that configures, starts and collects one auction round.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bids22_host #(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 3
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    bids22_host_if.master bus
);
    localparam logic [3:0] C_OP_NOOP      = 4'd0;
    localparam logic [3:0] C_OP_UNLOCK    = 4'd1;
    localparam logic [3:0] C_OP_LOCK      = 4'd2;
    localparam logic [3:0] C_OP_LOADX     = 4'd3;
    localparam logic [3:0] C_OP_LOADY     = 4'd4;
    localparam logic [3:0] C_OP_LOADZ     = 4'd5;
    localparam logic [3:0] C_OP_SETMASK   = 4'd6;
    localparam logic [3:0] C_OP_SETTIMER  = 4'd7;
    localparam logic [3:0] C_OP_SETCHARGE = 4'd8;
    localparam logic [1:0] C_ERR_BADKEY   = 2'd1;

    typedef enum logic [3:0] {
        S_IDLE, S_UNLOCK, S_UCHK, S_LOADX, S_LOADY, S_LOADZ, S_SETMASK,
        S_SETTIMER, S_SETCHARGE, S_LOCK, S_RUN, S_WAITOVER, S_REPORT
    } state_t;

    state_t                r_state;
    logic                  r_locked;
    logic [DATAWIDTH-1:0]  r_key;
    logic [DATAWIDTH-1:0]  r_cfg_key, r_x, r_y, r_z, r_timer, r_charge;
    logic [NUMBIDDERS-1:0] r_mask;
    logic [15:0]           r_roundlen;
    logic [15:0]           r_cnt;
    logic [2:0]            r_wcnt;
    logic [3:0]            r_op;
    logic [DATAWIDTH-1:0]  r_data;
    logic                  r_start;
    logic                  r_res_valid;
    logic [DATAWIDTH-1:0]  r_res_maxbid;
    logic [NUMBIDDERS-1:0] r_res_win;
    logic [1:0]            r_res_err;

    // Command outputs are registered: they are loaded on the transition into
    // the state that owns them, so each state presents its own command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_locked     <= 1'b0;
            r_key        <= '0;
            r_cfg_key    <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_z          <= '0;
            r_timer      <= '0;
            r_charge     <= '0;
            r_mask       <= '0;
            r_roundlen   <= '0;
            r_cnt        <= '0;
            r_wcnt       <= '0;
            r_op         <= C_OP_NOOP;
            r_data       <= '0;
            r_start      <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_maxbid <= '0;
            r_res_win    <= '0;
            r_res_err    <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.cfg_valid) begin
                    r_cfg_key  <= bus.cfg_key;
                    r_x        <= bus.cfg_x;
                    r_y        <= bus.cfg_y;
                    r_z        <= bus.cfg_z;
                    r_timer    <= bus.cfg_timer;
                    r_charge   <= bus.cfg_charge;
                    r_mask     <= bus.cfg_mask;
                    r_roundlen <= bus.cfg_roundlen;
                    if (r_locked) begin
                        r_state <= S_UNLOCK;
                        r_op    <= C_OP_UNLOCK;
                        r_data  <= r_key;
                    end else begin
                        r_state <= S_LOADX;
                        r_op    <= C_OP_LOADX;
                        r_data  <= bus.cfg_x;
                    end
                end
                S_UNLOCK: if (bus.ready) begin
                    r_state <= S_UCHK;
                    r_op    <= C_OP_NOOP;
                    r_data  <= '0;
                end
                S_UCHK: if (bus.err == C_ERR_BADKEY) begin
                    r_state      <= S_REPORT;
                    r_res_valid  <= 1'b1;
                    r_res_err    <= 2'd1;
                    r_res_maxbid <= '0;
                    r_res_win    <= '0;
                end else begin
                    r_state <= S_LOADX;
                    r_op    <= C_OP_LOADX;
                    r_data  <= r_x;
                end
                S_LOADX: if (bus.ready) begin
                    r_state <= S_LOADY;
                    r_op    <= C_OP_LOADY;
                    r_data  <= r_y;
                end
                S_LOADY: if (bus.ready) begin
                    r_state <= S_LOADZ;
                    r_op    <= C_OP_LOADZ;
                    r_data  <= r_z;
                end
                S_LOADZ: if (bus.ready) begin
                    r_state <= S_SETMASK;
                    r_op    <= C_OP_SETMASK;
                    r_data  <= DATAWIDTH'(r_mask);
                end
                S_SETMASK: if (bus.ready) begin
                    r_state <= S_SETTIMER;
                    r_op    <= C_OP_SETTIMER;
                    r_data  <= r_timer;
                end
                S_SETTIMER: if (bus.ready) begin
                    r_state <= S_SETCHARGE;
                    r_op    <= C_OP_SETCHARGE;
                    r_data  <= r_charge;
                end
                S_SETCHARGE: if (bus.ready) begin
                    r_state <= S_LOCK;
                    r_op    <= C_OP_LOCK;
                    r_data  <= r_cfg_key;
                end
                S_LOCK: if (bus.ready) begin
                    r_state  <= S_RUN;
                    r_op     <= C_OP_NOOP;
                    r_data   <= '0;
                    r_locked <= 1'b1;
                    r_key    <= r_cfg_key;
                    r_start  <= 1'b1;
                    r_cnt    <= (r_roundlen == 16'd0) ? 16'd1 : r_roundlen;
                end
                // r_cnt holds the number of RUN cycles still to go, this one included.
                S_RUN: if (r_cnt == 16'd1) begin
                    r_state <= S_WAITOVER;
                    r_start <= 1'b0;
                    r_cnt   <= '0;
                    r_wcnt  <= '0;
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
                S_WAITOVER: if (bus.roundOver) begin
                    r_state      <= S_REPORT;
                    r_res_valid  <= 1'b1;
                    r_res_maxbid <= bus.maxBid;
                    r_res_win    <= bus.win;
                    r_res_err    <= 2'd0;
                end else if (r_wcnt == 3'd7) begin
                    r_state      <= S_REPORT;
                    r_res_valid  <= 1'b1;
                    r_res_maxbid <= '0;
                    r_res_win    <= '0;
                    r_res_err    <= 2'd2;
                end else begin
                    r_wcnt <= r_wcnt + 3'd1;
                end
                S_REPORT: if (bus.res_ready) begin
                    r_state     <= S_IDLE;
                    r_res_valid <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cfg_ready  = (r_state == S_IDLE);
    assign bus.C_op       = r_op;
    assign bus.C_data     = r_data;
    assign bus.C_start    = r_start;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_maxbid = r_res_maxbid;
    assign bus.res_win    = r_res_win;
    assign bus.res_err    = r_res_err;

endmodule

`default_nettype wire

// File: tb/tb_bids22_host.sv
// ============================================================================
// Module   : tb_bids22_host
// Brief    : Directed self-checking bench for bids22_host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bids22_host;
    localparam logic [3:0] NOOP = 4'd0, UNLK = 4'd1, LCK = 4'd2, LDX = 4'd3,
                           LDY = 4'd4, LDZ = 4'd5, SMSK = 4'd6, STMR = 4'd7,
                           SCHG = 4'd8;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_start;

    bids22_host_if #(.DATAWIDTH(32), .NUMBIDDERS(3)) bus ();

    bids22_host #(.DATAWIDTH(32), .NUMBIDDERS(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input logic [3:0] op, input logic [31:0] data);
        check({tag, ".op"}, 64'(bus.C_op), 64'(op));
        check({tag, ".data"}, 64'(bus.C_data), 64'(data));
    endtask

    task automatic request(input logic [31:0] key, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z, input logic [2:0] mask, input logic [31:0] tmr,
                           input logic [31:0] chg, input logic [15:0] rlen);
        bus.cfg_key = key; bus.cfg_x = x; bus.cfg_y = y; bus.cfg_z = z;
        bus.cfg_mask = mask; bus.cfg_timer = tmr; bus.cfg_charge = chg;
        bus.cfg_roundlen = rlen;
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic loads(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         input logic [2:0] mask, input logic [31:0] tmr, input logic [31:0] chg,
                         input logic [31:0] key);
        check_cmd("loadx", LDX, x);       tick();
        check_cmd("loady", LDY, y);       tick();
        check_cmd("loadz", LDZ, z);       tick();
        check_cmd("setmask", SMSK, 32'(mask)); tick();
        check_cmd("settimer", STMR, tmr); tick();
        check_cmd("setcharge", SCHG, chg); tick();
        check_cmd("lock", LCK, key);      tick();
    endtask

    task automatic run_len(output int n);
        n = 0;
        while (bus.C_start === 1'b1 && n < 40) begin
            check_cmd("run", NOOP, 32'd0);
            n++;
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_key = '0; bus.cfg_x = '0; bus.cfg_y = '0;
        bus.cfg_z = '0; bus.cfg_timer = '0; bus.cfg_charge = '0; bus.cfg_mask = '0;
        bus.cfg_roundlen = '0; bus.ready = 1'b1; bus.roundOver = 1'b0;
        bus.maxBid = '0; bus.err = 2'd0; bus.win = '0; bus.res_ready = 1'b0;
        tick(); tick();
        check("rst.cfg_ready", 64'(bus.cfg_ready), 64'd1);
        check("rst.C_start", 64'(bus.C_start), 64'd0);
        check("rst.res_valid", 64'(bus.res_valid), 64'd0);
        check_cmd("rst", NOOP, 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle.cfg_ready", 64'(bus.cfg_ready), 64'd1);

        // Round 1: fresh from reset, no unlock, 4-cycle start, normal result.
        request(32'd5, 32'd100, 32'd100, 32'd100, 3'b111, 32'd10, 32'd1, 16'd4);
        check("r1.cfg_ready", 64'(bus.cfg_ready), 64'd0);
        loads(32'd100, 32'd100, 32'd100, 3'b111, 32'd10, 32'd1, 32'd5);
        run_len(n_start);
        check("r1.start_len", 64'(n_start), 64'd4);
        bus.roundOver = 1'b1; bus.maxBid = 32'd30; bus.win = 3'b010;
        bus.cfg_valid = 1'b1;
        tick();
        bus.roundOver = 1'b0; bus.maxBid = 32'd77; bus.win = 3'b111;
        check("r1.res_valid", 64'(bus.res_valid), 64'd1);
        check("r1.res_maxbid", 64'(bus.res_maxbid), 64'd30);
        check("r1.res_win", 64'(bus.res_win), 64'd2);
        check("r1.res_err", 64'(bus.res_err), 64'd0);
        tick(); tick();
        check("r1.hold_valid", 64'(bus.res_valid), 64'd1);
        check("r1.hold_maxbid", 64'(bus.res_maxbid), 64'd30);
        check("r1.hold_win", 64'(bus.res_win), 64'd2);
        bus.cfg_valid = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("r1.done_valid", 64'(bus.res_valid), 64'd0);
        check("r1.done_ready", 64'(bus.cfg_ready), 64'd1);

        // Round 2: unlock with old key, ready stall, timeout.
        request(32'd9, 32'd1, 32'd2, 32'd3, 3'b101, 32'd7, 32'd2, 16'd2);
        check_cmd("r2.unlock", UNLK, 32'd5); tick();
        check_cmd("r2.uchk", NOOP, 32'd0);   tick();
        bus.ready = 1'b0;
        check_cmd("r2.loadx_a", LDX, 32'd1); tick();
        check_cmd("r2.loadx_b", LDX, 32'd1); tick();
        bus.ready = 1'b1;
        check_cmd("r2.loadx_c", LDX, 32'd1); tick();
        check_cmd("r2.loady", LDY, 32'd2);   tick();
        check_cmd("r2.loadz", LDZ, 32'd3);   tick();
        check_cmd("r2.setmask", SMSK, 32'd5); tick();
        check_cmd("r2.settimer", STMR, 32'd7); tick();
        check_cmd("r2.setcharge", SCHG, 32'd2); tick();
        check_cmd("r2.lock", LCK, 32'd9);    tick();
        run_len(n_start);
        check("r2.start_len", 64'(n_start), 64'd2);
        bus.maxBid = 32'd55; bus.win = 3'b100;
        for (int i = 0; i < 7; i++) tick();
        check("r2.pre_timeout", 64'(bus.res_valid), 64'd0);
        tick();
        check("r2.to_valid", 64'(bus.res_valid), 64'd1);
        check("r2.to_err", 64'(bus.res_err), 64'd2);
        check("r2.to_maxbid", 64'(bus.res_maxbid), 64'd0);
        check("r2.to_win", 64'(bus.res_win), 64'd0);
        bus.res_ready = 1'b1; tick(); bus.res_ready = 1'b0;

        // Round 3: bad key rejected, no loads, no start.
        request(32'd11, 32'd4, 32'd4, 32'd4, 3'b011, 32'd1, 32'd1, 16'd3);
        check_cmd("r3.unlock", UNLK, 32'd9); tick();
        bus.err = 2'd1;
        check_cmd("r3.uchk", NOOP, 32'd0);   tick();
        bus.err = 2'd0;
        check("r3.res_valid", 64'(bus.res_valid), 64'd1);
        check("r3.res_err", 64'(bus.res_err), 64'd1);
        check("r3.C_start", 64'(bus.C_start), 64'd0);
        check_cmd("r3.report", NOOP, 32'd0);
        bus.res_ready = 1'b1; tick(); bus.res_ready = 1'b0;

        // Round 4: key unchanged by the failed round, roundlen 0 gives one start cycle.
        request(32'd12, 32'd6, 32'd7, 32'd8, 3'b110, 32'd3, 32'd4, 16'd0);
        check_cmd("r4.unlock", UNLK, 32'd9); tick();
        tick();
        loads(32'd6, 32'd7, 32'd8, 3'b110, 32'd3, 32'd4, 32'd12);
        run_len(n_start);
        check("r4.start_len", 64'(n_start), 64'd1);
        bus.roundOver = 1'b1; bus.maxBid = 32'd8; bus.win = 3'b011;
        tick();
        bus.roundOver = 1'b0;
        check("r4.res_maxbid", 64'(bus.res_maxbid), 64'd8);
        check("r4.res_win_multi", 64'(bus.res_win), 64'd3);
        bus.res_ready = 1'b1; tick(); bus.res_ready = 1'b0;

        // Round 5: reset during the second RUN cycle.
        request(32'd13, 32'd1, 32'd1, 32'd1, 3'b111, 32'd1, 32'd1, 16'd4);
        check_cmd("r5.unlock", UNLK, 32'd12); tick();
        tick();
        loads(32'd1, 32'd1, 32'd1, 3'b111, 32'd1, 32'd1, 32'd13);
        check("r5.run1", 64'(bus.C_start), 64'd1);
        tick();
        check("r5.run2", 64'(bus.C_start), 64'd1);
        reset_n = 1'b0;
        #1;
        check("r5.rst_start", 64'(bus.C_start), 64'd0);
        check("r5.rst_ready", 64'(bus.cfg_ready), 64'd1);
        tick();
        reset_n = 1'b1;
        tick();
        check("r5.post_ready", 64'(bus.cfg_ready), 64'd1);
        request(32'd14, 32'd21, 32'd22, 32'd23, 3'b001, 32'd2, 32'd3, 16'd1);
        check_cmd("r6.no_unlock", LDX, 32'd21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
